// File: rtl/demux_reg.sv
// rtl/demux_reg.sv - registered 1-to-2 demultiplexer with per-output holding registers and delivery counters
module demux_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             select,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    slot_t state1_q, state1_d;
    slot_t state2_q, state2_d;

    logic take;
    logic load1, load2;
    logic drain1, drain2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state1_q <= EMPTY;
            state2_q <= EMPTY;
        end else begin
            state1_q <= state1_d;
            state2_q <= state2_d;
        end
    end

    // in_ready looks only at the selected slot so a stalled consumer never blocks the other one
    always_comb begin
        in_ready = 1'b0;
        take     = 1'b0;
        load1    = 1'b0;
        load2    = 1'b0;
        drain1   = 1'b0;
        drain2   = 1'b0;
        state1_d = state1_q;
        state2_d = state2_q;

        if (select)
            in_ready = rst_n && ((state2_q == EMPTY) || out2_ready);
        else
            in_ready = rst_n && ((state1_q == EMPTY) || out1_ready);

        take   = in_valid && in_ready;
        load1  = take && !select;
        load2  = take && select;
        drain1 = (state1_q == FULL) && out1_ready;
        drain2 = (state2_q == FULL) && out2_ready;

        if (load1)
            state1_d = FULL;
        else if (drain1)
            state1_d = EMPTY;

        if (load2)
            state2_d = FULL;
        else if (drain2)
            state2_d = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_data <= '0;
            out2_data <= '0;
            cnt1      <= '0;
            cnt2      <= '0;
        end else begin
            if (load1)
                out1_data <= in_data;
            if (load2)
                out2_data <= in_data;
            if (drain1)
                cnt1 <= cnt1 + CNT_W'(1);
            if (drain2)
                cnt2 <= cnt2 + CNT_W'(1);
        end
    end

    assign out1_valid = (state1_q == FULL);
    assign out2_valid = (state2_q == FULL);

endmodule

// File: tb/tb_demux_reg.sv
// tb/tb_demux_reg.sv - self-checking bench for demux_reg with a per-slot reference model
module tb_demux_reg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             select;
    logic             in_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out2_data;
    logic             out2_valid;
    logic             out2_ready;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;

    int total = 0;
    int bad   = 0;

    demux_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .select     (select),
        .in_ready   (in_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .cnt1       (cnt1),
        .cnt2       (cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each output is a one-deep slot; index 0 = output 1, index 1 = output 2
    logic             m_full [2];
    logic [WIDTH-1:0] m_data [2];
    logic [CNT_W-1:0] m_cnt  [2];

    function automatic logic rdy(input int k);
        return (k == 0) ? out1_ready : out2_ready;
    endfunction

    function automatic logic m_ready();
        int s;
        s = select ? 1 : 0;
        return !m_full[s] || rdy(s);
    endfunction

    always @(negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = '0;
            m_cnt[k]  = '0;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            logic acc;
            int   s;
            s   = select ? 1 : 0;
            acc = in_valid && m_ready();
            for (int k = 0; k < 2; k++) begin
                if (m_full[k] && rdy(k)) begin
                    m_cnt[k]  = m_cnt[k] + 1'b1;
                    m_full[k] = 1'b0;
                end
            end
            if (acc) begin
                m_full[s] = 1'b1;
                m_data[s] = in_data;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_in_ready", in_ready, m_ready());
            chk("m_out1_valid", out1_valid, m_full[0]);
            chk("m_out2_valid", out2_valid, m_full[1]);
            chk("m_out1_data", out1_data, m_data[0]);
            chk("m_out2_data", out2_data, m_data[1]);
            chk("m_cnt1", cnt1, m_cnt[0]);
            chk("m_cnt2", cnt2, m_cnt[1]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = '0;
        in_valid   = 1'b1;
        select     = 1'b0;
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        #3;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out1_valid", out1_valid, 1'b0);
        chk("rst_cnt1", cnt1, 8'h00);
        in_valid = 1'b0;
        cyc();
        rst_n = 1'b1;

        // basic routing
        in_data = 32'h0000_00A5; select = 1'b0; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("route_out1_valid", out1_valid, 1'b1);
        chk("route_out1_data", out1_data, 32'hA5);
        chk("route_out2_valid", out2_valid, 1'b0);
        out1_ready = 1'b1;
        cyc();
        out1_ready = 1'b0;
        chk("route_drained", out1_valid, 1'b0);
        chk("route_cnt1", cnt1, 8'd1);

        // backpressure on output 2
        in_data = 32'h11; select = 1'b1; in_valid = 1'b1;
        cyc();
        in_data = 32'h22;
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_hold_11", out2_data, 32'h11);
        cyc();
        chk("bp_still_11", out2_data, 32'h11);
        out2_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", in_ready, 1'b1);
        cyc();
        out2_ready = 1'b0; in_valid = 1'b0;
        chk("bp_out2_22", out2_data, 32'h22);
        chk("bp_out2_valid", out2_valid, 1'b1);
        chk("bp_cnt2", cnt2, 8'd1);

        // slot 2 stalled, slot 1 still accepts
        in_data = 32'h33; select = 1'b0; in_valid = 1'b1;
        #1;
        chk("nb_in_ready", in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
        chk("nb_out1_33", out1_data, 32'h33);
        chk("nb_out2_22", out2_data, 32'h22);
        out1_ready = 1'b1;
        cyc();
        chk("nb_cnt1", cnt1, 8'd2);

        // full throughput on output 1
        for (int i = 0; i < 10; i++) begin
            in_data = WIDTH'(i); select = 1'b0; in_valid = 1'b1;
            #1;
            chk("tp_in_ready", in_ready, 1'b1);
            cyc();
            chk("tp_out1_data", out1_data, 64'(i));
            chk("tp_out1_valid", out1_valid, 1'b1);
        end
        in_valid = 1'b0;
        cyc();
        chk("tp_cnt1", cnt1, 8'd12);
        out1_ready = 1'b0;

        // simultaneous drain of both slots
        in_data = 32'h44; select = 1'b0; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        out1_ready = 1'b1; out2_ready = 1'b1;
        cyc();
        out1_ready = 1'b0; out2_ready = 1'b0;
        chk("both_cnt1", cnt1, 8'd13);
        chk("both_cnt2", cnt2, 8'd2);
        chk("both_v1", out1_valid, 1'b0);
        chk("both_v2", out2_valid, 1'b0);

        // asynchronous reset with both slots full
        in_data = 32'h55; select = 1'b0; in_valid = 1'b1;
        cyc();
        in_data = 32'h66; select = 1'b1;
        cyc();
        chk("pre_rst_full", {out1_valid, out2_valid}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1'b0);
        chk("arst_valids", {out1_valid, out2_valid}, 2'b00);
        chk("arst_data", {out1_data, out2_data}, 64'h0);
        chk("arst_cnts", {cnt1, cnt2}, 16'h0);
        in_valid = 1'b0;
        cyc();
        rst_n = 1'b1;

        // counter wrap on output 1; out2_ready idles high on an empty slot
        out1_ready = 1'b1; out2_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = WIDTH'(i + 256); select = 1'b0; in_valid = 1'b1;
            cyc();
        end
        chk("wrap_cnt1_255", cnt1, 8'hFF);
        chk("wrap_last_data", out1_data, 32'h1FF);
        in_valid = 1'b0;
        cyc();
        chk("wrap_cnt1_0", cnt1, 8'h00);
        chk("wrap_cnt2", cnt2, 8'h00);
        chk("wrap_v1", out1_valid, 1'b0);
        out1_ready = 1'b0; out2_ready = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_reg.md
Name: demux_reg

Overview:
- Registered 1-to-2 demultiplexer; the inverse of the datapath 2:1 mux.
- Routes one WIDTH-bit input word to one of two outputs, chosen by `select`.
- Each output has a single-entry holding register and a valid/ready handshake.
- Used where a single producer (e.g. write-back or ALU result) must feed one of two pipelined consumers without combinational paths from output to input data.

Parameters:
- WIDTH, 32, data width of input and both outputs
- CNT_W, 8, width of the per-output delivered-word counters

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  word to route
- in_valid  input  1  in_data/select valid this cycle
- select  input  1  0 -> output 1, 1 -> output 2; sampled with in_valid
- in_ready  output  1  demux accepts the word this cycle
- out1_data  output  WIDTH  holding register 1 contents
- out1_valid  output  1  holding register 1 full
- out1_ready  input  1  consumer 1 takes out1_data this cycle
- out2_data  output  WIDTH  holding register 2 contents
- out2_valid  output  1  holding register 2 full
- out2_ready  input  1  consumer 2 takes out2_data this cycle
- cnt1  output  CNT_W  words delivered on output 1 (wraps)
- cnt2  output  CNT_W  words delivered on output 2 (wraps)

Behaviour:
- Reset:
  - Asserting rst_n=0 immediately clears out1_valid, out2_valid, out1_data, out2_data, cnt1 and cnt2 to 0, independent of clk.
  - in_ready is 0 while rst_n=0.
  - Reset mid-transfer discards held words; no partial state survives.
- Each holding register has two states, EMPTY (valid=0) and FULL (valid=1).
- Accept condition:
  - in_ready = slot[select] EMPTY, or slot[select] FULL and out_ready[select]=1.
  - in_ready depends combinationally on select and out_ready of the selected slot only, never on in_data.
  - Transfer in occurs when in_valid and in_ready are both 1 at the clk edge.
- Drain condition: out_valid[k] and out_ready[k] both 1 at the clk edge. On drain, cnt[k] increments by 1, modulo 2^CNT_W (0xFF -> 0x00 at default).
- Slot transitions per clock edge, for slot k:
  - EMPTY + transfer-in to k -> FULL, data loaded.
  - FULL + drain, no transfer-in to k -> EMPTY; data register holds its stale value.
  - FULL + drain + transfer-in to k in the same cycle -> stays FULL with the new data. Throughput is 1 word/cycle; counter increments.
  - FULL, no drain -> holds data; in_ready=0 when select=k.
- Latency: exactly 1 cycle from the accepting edge to out_valid. There is no combinational path from in_data to outk_data.
- Independence:
  - A stalled slot never blocks traffic to the other slot. Words selecting the free slot are accepted while the other is FULL.
  - Both slots may drain in the same cycle.
- Consumer rules:
  - out_ready asserted while out_valid=0 has no effect and does not change the counter.
  - out_data is stable for as long as out_valid=1 and out_ready=0.
- Producer rules:
  - in_data and select must be held while in_valid=1 and in_ready=0.
  - Changing select while stalled is a protocol violation; the block still routes by the value sampled on the accepting edge.
- Ordering: words destined for the same output leave in acceptance order. There is no ordering relation between the two outputs.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with both slots FULL -> out1_valid, out2_valid, cnt1 and cnt2 read 0 immediately, before the next clk edge; in_ready=0 while rst_n=0.
- Basic routing: in_data=0x0000_00A5, select=0, in_valid=1 for one cycle -> next cycle out1_valid=1, out1_data=0xA5, out2_valid=0. Then out1_ready=1 -> out1_valid=0 and cnt1=1.
- Backpressure: out2_ready=0; send 0x11 then 0x22, both with select=1 -> 0x11 held on out2, in_ready=0 for the second word. After out2_ready=1 for one cycle, 0x22 is accepted that same cycle, appears on out2 the next cycle, and cnt2=1.
- Non-blocking: slot 2 FULL and stalled; send 0x33 with select=0 -> accepted immediately, out1_data=0x33 next cycle, out2_data unchanged.
- Full throughput: out1_ready=1 constant; stream 0..9 with select=0 back-to-back -> in_ready stays 1, out1 shows 0..9 on consecutive cycles, cnt1=10.
- Counter wrap: deliver 256 words on output 1 -> cnt1 reads 0 after the 256th drain, and cnt2 is unaffected.
